// File: rtl/vclk_switch_sequencer_pkg.sv
// Shared types and defaults for the video clock switch sequencer.
package n64adv_vclk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_LOCK = 2'd2,
    SETTLE    = 2'd3
  } vclk_seq_state_e;

  localparam int DEF_PRE_HOLD_CYCLES     = 4;
  localparam int DEF_LOCK_STABLE_CYCLES  = 4;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 4096;
  localparam int DEF_SETTLE_CYCLES       = 16;

  // VCLK_select bit that routes the 75 MHz PLL output
  localparam int SEL_75M_BIT = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vclk_switch_sequencer_if.sv
// Valid/ready request channel carrying a new VCLK_select value.
interface vclk_req_if;
  logic [1:0] req_select;
  logic       req_valid;
  logic       req_ready;

  modport master (output req_select, output req_valid, input req_ready);
  modport slave  (input req_select, input req_valid, output req_ready);
endinterface

// File: rtl/vclk_switch_sequencer_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/vclk_switch_sequencer.sv
// Sequences VCLK_select changes behind video_hold and supervises the 75 MHz PLL lock.
// Optional macro VCLK_LOCK_FALLBACK_EN: on lock timeout drop back to the non-PLL clock.
import n64adv_vclk_seq_pkg::*;

module vclk_switch_sequencer #(
  parameter int PRE_HOLD_CYCLES     = DEF_PRE_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES       = DEF_SETTLE_CYCLES
) (
  input  logic       SYS_CLK,
  input  logic       SRST,
  vclk_req_if.slave  req,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] VCLK_select,
  output logic       video_hold,
  output logic       lock_err
);

  localparam int CW = $clog2(max4(PRE_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES)) + 1;

  localparam logic [CW-1:0] PRE_LAST     = CW'(PRE_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

  vclk_seq_state_e state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   stab;
  logic [1:0]      sel_pend;
  logic            lock_s;
  logic            accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  bit_synchronizer u_lock_sync (
    .clk (SYS_CLK),
    .rst (SRST),
    .d   (VCLK_PLL_LOCKED),
    .q   (lock_s)
  );

  assign req.req_ready = (state == IDLE);
  assign accept        = req.req_valid & req.req_ready;

  always_ff @(posedge SYS_CLK or posedge SRST) begin
    if (SRST) begin
      state       <= IDLE;
      cnt         <= '0;
      stab        <= '0;
      sel_pend    <= 2'b00;
      VCLK_select <= 2'b00;
      video_hold  <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // A request wins over a simultaneous lock loss; its own sequence re-waits for lock
            lock_err <= 1'b0;
            if (req.req_select != VCLK_select) begin
              sel_pend   <= req.req_select;
              state      <= HOLD;
              video_hold <= 1'b1;
              cnt        <= '0;
            end
          end else if (VCLK_select[SEL_75M_BIT] && !lock_s) begin
            state      <= WAIT_LOCK;
            video_hold <= 1'b1;
            cnt        <= '0;
            stab       <= '0;
          end
        end

        HOLD: begin
          if (cnt == PRE_LAST) begin
            VCLK_select <= sel_pend;
            cnt         <= '0;
            stab        <= '0;
            state       <= sel_pend[SEL_75M_BIT] ? WAIT_LOCK : SETTLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        WAIT_LOCK: begin
          stab <= lock_s ? sat_inc(stab) : '0;
          if (lock_s && stab == STABLE_LAST) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            lock_err <= 1'b1;
            cnt      <= '0;
`ifdef VCLK_LOCK_FALLBACK_EN
            VCLK_select[SEL_75M_BIT] <= 1'b0;
            state                    <= SETTLE;
`else
            // Keep waiting on the requested clock; the timeout only flags the error
            state <= WAIT_LOCK;
`endif
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state      <= IDLE;
            video_hold <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state      <= IDLE;
          video_hold <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/vclk_switch_sequencer.md
# vclk_switch_sequencer

Controller-side initiator for the video clock selection consumed by the clock/reset housekeeping. Runs in the system clock domain, accepts a requested `VCLK_select` value from the NIOS II/controller via a valid/ready handshake, and sequences the switch: hold the video pipeline, apply the new selection, wait for the 75 MHz video PLL to lock when it is selected, let it settle, release. It also supervises PLL lock while the 75 MHz clock is in use.

## Interface
Parameters:
- `PRE_HOLD_CYCLES`, 4: cycles `video_hold` is high before `VCLK_select` changes (≥1).
- `LOCK_STABLE_CYCLES`, 4: consecutive synchronized-lock-high cycles required (≥1).
- `LOCK_TIMEOUT_CYCLES`, 4096: maximum cycles spent in WAIT_LOCK.
- `SETTLE_CYCLES`, 16: cycles after lock/select before hold release (≥1).

Ports:
- `SYS_CLK`  in  1  system clock (4 MHz controller clock).
- `SRST`  in  1  reset: one clock; reset is asynchronous and active-high.
- `req_select`  in  2  requested VCLK_select value.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; accept on `req_valid & req_ready`.
- `VCLK_PLL_LOCKED`  in  1  video PLL lock, asynchronous to `SYS_CLK`.
- `VCLK_select`  out  2  registered clock selection; bit 1 selects the 75 MHz clock.
- `video_hold`  out  1  registered, high while a switch or recovery is in progress.
- `lock_err`  out  1  sticky, set on lock timeout, cleared on the next accepted request.

## Operation
- Reset values: `VCLK_select`=2'b00, `video_hold`=0, `lock_err`=0, state IDLE, counters 0, synchronizer 0. `req_ready`=1 once reset is released.
- `VCLK_PLL_LOCKED` passes through a 2-flop synchronizer. `lock_s` is the synchronizer output.
- States:
  - IDLE: `req_ready`=1.
    - Accept with `req_select`==`VCLK_select`: no state change and no hold. `lock_err` is cleared.
    - Accept with a different value: latch the value, clear `lock_err`, go to HOLD.
    - With `VCLK_select[1]`=1 and `lock_s`=0 with no accept in the same cycle: go to WAIT_LOCK (lock-loss recovery).
    - A simultaneous accept and lock loss: the accept wins. The new request's sequence covers lock waiting.
  - HOLD: count `PRE_HOLD_CYCLES`. On the last cycle, load `VCLK_select` with the latched value. Then:
    - go to WAIT_LOCK if the new bit 1 = 1;
    - otherwise go to SETTLE.
  - WAIT_LOCK: the stable counter increments while `lock_s`=1 and resets to 0 when `lock_s`=0.
    - When the stable counter reaches `LOCK_STABLE_CYCLES`, go to SETTLE.
    - When the timeout counter reaches `LOCK_TIMEOUT_CYCLES`: set `lock_err` and apply the timeout behaviour (see Configuration).
  - SETTLE: count `SETTLE_CYCLES`, then go to IDLE.
- `video_hold`=1 in HOLD, WAIT_LOCK and SETTLE. It is 0 in IDLE.
- Counters are sized `$clog2(max parameter)+1` bits, saturate, and are cleared on every state entry.
- `req_select`/`req_valid` are ignored outside IDLE. Requests are never queued.
- `SRST` mid-sequence returns all outputs to their reset values immediately (asynchronously).

## Timing
- Accept at cycle N:
  - `video_hold`=1 from N+1.
  - `VCLK_select` takes the new value at N+`PRE_HOLD_CYCLES`+1.
- Direct VCLK target (bit 1 = 0): `video_hold` falls at N+`PRE_HOLD_CYCLES`+`SETTLE_CYCLES`+1, and `req_ready` rises in the same cycle.
- 75 MHz target: add the lock wait. That is ≥ the 2-cycle synchronizer delay plus `LOCK_STABLE_CYCLES`.
- Lock-loss recovery: `lock_s` falls at cycle M (≥2 cycles after `VCLK_PLL_LOCKED` falls). `video_hold`=1 and `req_ready`=0 from M+1.

## Configuration
- `VCLK_LOCK_FALLBACK_EN` defined: on lock timeout, force `VCLK_select[1]`=0 (bit 0 kept), then SETTLE then IDLE. In IDLE with bit 1 = 0 no lock monitoring occurs.
- Not defined: on lock timeout, keep the requested selection, set `lock_err`, restart the timeout counter and remain in WAIT_LOCK until the lock is stable or `SRST`. `video_hold` stays high.

## Structure
- Package `n64adv_vclk_seq_pkg` contains:
  - the state enum (IDLE, HOLD, WAIT_LOCK, SETTLE);
  - the default parameter constants;
  - the `VCLK_select` bit index constant for the 75 MHz selection.
- One sub-module, `bit_synchronizer`: a 2-stage flop chain with asynchronous active-high reset, used for `VCLK_PLL_LOCKED`.

## Test plan
- Reset, then request 2'b01 from 2'b00 at cycle 10 → `video_hold` high at 11, `VCLK_select`=01 at 15, `video_hold` low and `req_ready` high at 31.
- Request 2'b10 with `VCLK_PLL_LOCKED` rising 20 cycles after the select change → SETTLE begins only after 4 consecutive high `lock_s` cycles, and `lock_err` stays 0.
- Request 2'b10 with the lock never asserted:
  - with the macro: `lock_err`=1 after 4096 WAIT_LOCK cycles, `VCLK_select`=00, then IDLE after 16 cycles;
  - without the macro: the block stays in WAIT_LOCK with hold high.
- In IDLE with 2'b10 selected, drop the lock for 50 cycles → `video_hold` rises about 3 cycles later, `req_ready`=0, and hold is released after lock-stable plus settle.
- Request equal to the current select → accepted in one cycle, `video_hold` never rises, `lock_err` cleared. Pulse `req_valid` during HOLD → ignored.
- Assert `SRST` in WAIT_LOCK → all outputs return to their reset values in the same cycle, and a normal switch works afterwards.
